// File: rtl/d_reg_pipe.sv
// Multi-channel enable-advanced capture pipeline with a run-time transparent
// (latch-emulation) output mode, synchronous clear, valid tracking and change detect.
module d_reg_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       q_vld,
    output logic [CHANNELS-1:0]       chg
);

    localparam int unsigned LAST = DEPTH - 1;

    logic [WIDTH-1:0]    data_q [CHANNELS][DEPTH];
    logic [WIDTH-1:0]    data_d [CHANNELS][DEPTH];
    logic [DEPTH-1:0]    vld_q  [CHANNELS];
    logic [DEPTH-1:0]    vld_d  [CHANNELS];
    logic [CHANNELS-1:0] chg_q;
    logic [CHANNELS-1:0] chg_d;

    always_comb begin
        chg_d = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            data_d[c] = data_q[c];
            vld_d[c]  = vld_q[c];
            if (clr) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    data_d[c][k] = '0;
                end
                vld_d[c] = '0;
            end else if (en[c]) begin
                data_d[c][0] = d[c*WIDTH +: WIDTH];
                vld_d[c][0]  = 1'b1;
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    data_d[c][k] = data_q[c][k-1];
                    vld_d[c][k]  = vld_q[c][k-1];
                end
            end
            // Change is judged on whichever stage currently feeds q.
            if (mode) begin
                chg_d[c] = ~clr & en[c] & vld_d[c][0]
                         & (data_d[c][0] != data_q[c][0]);
            end else begin
                chg_d[c] = ~clr & en[c] & vld_d[c][LAST]
                         & (data_d[c][LAST] != data_q[c][LAST]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    data_q[c][k] <= '0;
                end
                vld_q[c] <= '0;
            end
            chg_q <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            chg_q  <= chg_d;
        end
    end

    // Reset gates the transparent bypass so q stays 0 while rst_n is held.
    always_comb begin
        q     = '0;
        q_vld = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!rst_n) begin
                q[c*WIDTH +: WIDTH] = '0;
                q_vld[c]            = 1'b0;
            end else if (mode) begin
                q[c*WIDTH +: WIDTH] = en[c] ? d[c*WIDTH +: WIDTH] : data_q[c][0];
                q_vld[c]            = en[c] | vld_q[c][0];
            end else begin
                q[c*WIDTH +: WIDTH] = data_q[c][LAST];
                q_vld[c]            = vld_q[c][LAST];
            end
        end
    end

    assign chg = chg_q;

endmodule

// File: tb/tb_d_reg_pipe.sv
// Scenario bench for d_reg_pipe (WIDTH=8, CHANNELS=4, DEPTH=2): expected outputs are
// queued as stimulus is applied and popped when the DUT result is sampled.
module tb_d_reg_pipe;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        mode;
    logic [3:0]  en;
    logic [31:0] d;
    logic [31:0] q;
    logic [3:0]  q_vld;
    logic [3:0]  chg;

    typedef struct {
        int         ch;
        logic [7:0] q;
        logic       v;
        logic       c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    d_reg_pipe #(.WIDTH(8), .CHANNELS(4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
        .en(en), .d(d), .q(q), .q_vld(q_vld), .chg(chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; mode = 1'b0; en = '0; d = '0;
        tick(); tick();
        n_cmp++; if (q !== 32'h0)  begin n_err++; $display("FAIL reset_q got %h want %h", q, 32'h0); end
        n_cmp++; if (q_vld !== 4'h0) begin n_err++; $display("FAIL reset_vld got %b want %b", q_vld, 4'h0); end
        n_cmp++; if (chg !== 4'h0) begin n_err++; $display("FAIL reset_chg got %b want %b", chg, 4'h0); end
        // transparent bypass must also be suppressed while reset is held
        mode = 1'b1; en = 4'hF; d = 32'hDEADBEEF;
        #1;
        n_cmp++; if (q !== 32'h0)  begin n_err++; $display("FAIL reset_q_mode1 got %h want %h", q, 32'h0); end
        n_cmp++; if (q_vld !== 4'h0) begin n_err++; $display("FAIL reset_vld_mode1 got %b want %b", q_vld, 4'h0); end
        mode = 1'b0; en = '0; d = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_registered();
        logic [7:0] dv [3] = '{8'h11, 8'h22, 8'h22};
        en = 4'b0001; d[7:0] = 8'h11;
        #1;
        sb.push_back('{0, 8'h00, 1'b0, 1'b0});
        e = sb.pop_front();
        n_cmp++; if (q_vld[0] !== e.v) begin n_err++; $display("FAIL reg_pre_vld got %b want %b", q_vld[0], e.v); end
        sb.push_back('{0, 8'h00, 1'b0, 1'b0});
        sb.push_back('{0, 8'h11, 1'b1, 1'b1});
        sb.push_back('{0, 8'h22, 1'b1, 1'b1});
        for (int i = 0; i < 3; i++) begin
            d[7:0] = dv[i];
            tick();
            e = sb.pop_front();
            n_cmp++; if (q[7:0] !== e.q)   begin n_err++; $display("FAIL reg_q[%0d] got %h want %h", i, q[7:0], e.q); end
            n_cmp++; if (q_vld[0] !== e.v) begin n_err++; $display("FAIL reg_vld[%0d] got %b want %b", i, q_vld[0], e.v); end
            n_cmp++; if (chg[0] !== e.c)   begin n_err++; $display("FAIL reg_chg[%0d] got %b want %b", i, chg[0], e.c); end
        end
    endtask

    task automatic test_stall();
        logic       ev [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
        logic [7:0] dv [8] = '{8'h33, 8'h44, 8'h33, 8'h44, 8'h33, 8'h55, 8'h55, 8'h55};
        for (int i = 0; i < 5; i++) sb.push_back('{0, 8'h22, 1'b1, 1'b0});
        sb.push_back('{0, 8'h22, 1'b1, 1'b0});
        sb.push_back('{0, 8'h55, 1'b1, 1'b1});
        sb.push_back('{0, 8'h55, 1'b1, 1'b0});
        for (int i = 0; i < 8; i++) begin
            en[0] = ev[i]; d[7:0] = dv[i];
            tick();
            e = sb.pop_front();
            n_cmp++; if (q[7:0] !== e.q)   begin n_err++; $display("FAIL stall_q[%0d] got %h want %h", i, q[7:0], e.q); end
            n_cmp++; if (q_vld[0] !== e.v) begin n_err++; $display("FAIL stall_vld[%0d] got %b want %b", i, q_vld[0], e.v); end
            n_cmp++; if (chg[0] !== e.c)   begin n_err++; $display("FAIL stall_chg[%0d] got %b want %b", i, chg[0], e.c); end
        end
        en = '0;
    endtask

    task automatic test_transparent();
        mode = 1'b1; en = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d[15:8] = 8'hA0 + 8'(i);
            sb.push_back('{1, 8'hA0 + 8'(i), 1'b1, 1'b0});
            #1;
            e = sb.pop_front();
            n_cmp++; if (q[15:8] !== e.q)  begin n_err++; $display("FAIL transp_q[%0d] got %h want %h", i, q[15:8], e.q); end
            n_cmp++; if (q_vld[1] !== e.v) begin n_err++; $display("FAIL transp_vld[%0d] got %b want %b", i, q_vld[1], e.v); end
        end
        tick();
        en = '0; d[15:8] = 8'hFF;
        for (int i = 0; i < 3; i++) sb.push_back('{1, 8'hA5, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick(); else #1;
            e = sb.pop_front();
            n_cmp++; if (q[15:8] !== e.q)  begin n_err++; $display("FAIL hold_q[%0d] got %h want %h", i, q[15:8], e.q); end
            n_cmp++; if (q_vld[1] !== e.v) begin n_err++; $display("FAIL hold_vld[%0d] got %b want %b", i, q_vld[1], e.v); end
            if (i > 0) begin
                n_cmp++; if (chg[1] !== e.c) begin n_err++; $display("FAIL hold_chg[%0d] got %b want %b", i, chg[1], e.c); end
            end
        end
    endtask

    task automatic test_independence();
        logic [7:0] eq [4] = '{8'h7E, 8'hA5, 8'h7E, 8'h00};
        logic       evl [4] = '{1, 1, 1, 0};
        logic       ec1 [4] = '{1, 0, 1, 0};
        mode = 1'b1; en = 4'b0101; d = {4{8'h7E}};
        for (int c = 0; c < 4; c++) sb.push_back('{c, eq[c], evl[c], ec1[c]});
        for (int c = 0; c < 4; c++) sb.push_back('{c, eq[c], evl[c], 1'b0});
        for (int c = 0; c < 4; c++) sb.push_back('{c, eq[c], evl[c], 1'b0});
        for (int ph = 0; ph < 3; ph++) begin
            if (ph < 2) tick();
            else begin en = '0; #1; end
            for (int c = 0; c < 4; c++) begin
                e = sb.pop_front();
                n_cmp++; if (q[e.ch*8 +: 8] !== e.q) begin n_err++; $display("FAIL indep_q ph%0d ch%0d got %h want %h", ph, e.ch, q[e.ch*8 +: 8], e.q); end
                n_cmp++; if (q_vld[e.ch] !== e.v)    begin n_err++; $display("FAIL indep_vld ph%0d ch%0d got %b want %b", ph, e.ch, q_vld[e.ch], e.v); end
                n_cmp++; if (chg[e.ch] !== e.c)      begin n_err++; $display("FAIL indep_chg ph%0d ch%0d got %b want %b", ph, e.ch, chg[e.ch], e.c); end
            end
        end
    endtask

    task automatic test_clr();
        mode = 1'b0; clr = 1'b1; en = 4'hF; d = {4{8'h99}};
        for (int n = 0; n < 12; n++) sb.push_back('{n % 4, 8'h00, 1'b0, 1'b0});
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 0) begin tick(); clr = 1'b0; en = '0; #1; end
            else if (ph == 1) begin mode = 1'b1; #1; end
            else tick();
            for (int c = 0; c < 4; c++) begin
                e = sb.pop_front();
                n_cmp++; if (q[e.ch*8 +: 8] !== e.q) begin n_err++; $display("FAIL clr_q ph%0d ch%0d got %h want %h", ph, e.ch, q[e.ch*8 +: 8], e.q); end
                n_cmp++; if (q_vld[e.ch] !== e.v)    begin n_err++; $display("FAIL clr_vld ph%0d ch%0d got %b want %b", ph, e.ch, q_vld[e.ch], e.v); end
                n_cmp++; if (chg[e.ch] !== e.c)      begin n_err++; $display("FAIL clr_chg ph%0d ch%0d got %b want %b", ph, e.ch, chg[e.ch], e.c); end
            end
        end
    endtask

    task automatic test_async_reset();
        mode = 1'b0; en = 4'hF; d = 32'h14131211;
        for (int c = 0; c < 4; c++) sb.push_back('{c, 8'h11 + 8'(c), 1'b1, 1'b1});
        for (int c = 0; c < 4; c++) sb.push_back('{c, 8'h00, 1'b0, 1'b0});
        sb.push_back('{0, 8'h3C, 1'b1, 1'b1});
        for (int c = 1; c < 4; c++) sb.push_back('{c, 8'h00, 1'b0, 1'b0});
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 0) begin tick(); tick(); end
            else if (ph == 1) begin #2; rst_n = 1'b0; #1; end
            else begin
                #2; rst_n = 1'b1;
                mode = 1'b1; en = 4'b0001; d = 32'h0000003C;
                tick();
                en = '0; #1;
            end
            for (int c = 0; c < 4; c++) begin
                e = sb.pop_front();
                n_cmp++; if (q[e.ch*8 +: 8] !== e.q) begin n_err++; $display("FAIL arst_q ph%0d ch%0d got %h want %h", ph, e.ch, q[e.ch*8 +: 8], e.q); end
                n_cmp++; if (q_vld[e.ch] !== e.v)    begin n_err++; $display("FAIL arst_vld ph%0d ch%0d got %b want %b", ph, e.ch, q_vld[e.ch], e.v); end
                n_cmp++; if (chg[e.ch] !== e.c)      begin n_err++; $display("FAIL arst_chg ph%0d ch%0d got %b want %b", ph, e.ch, chg[e.ch], e.c); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_registered();
        test_stall();
        test_transparent();
        test_independence();
        test_clr();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
